seq_bw_multiplier: RTL and testbench

//  Iterative signed/unsigned MxN multiplier: Baugh-Wooley row formulation, one

---
 rtl/seq_bw_multiplier_if.sv | 25 ++
 rtl/seq_bw_multiplier.sv | 118 +++++++++++
 tb/tb_seq_bw_multiplier.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_bw_multiplier_if.sv
// Handshake and operand bundle for seq_bw_multiplier.
// The master side requests operations; the slave side is the multiplier.
interface seq_bw_multiplier_if #(
    parameter int M = 4,
    parameter int N = 4
);
    logic             start;
    logic             sgn;
    logic             acc_en;
    logic [M-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [M+N-1:0]   p;

    modport master (
        output start, sgn, acc_en, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, sgn, acc_en, a, b,
        output busy, done, p
    );
endinterface

// File: rtl/seq_bw_multiplier.sv
// Iterative Baugh-Wooley MxN multiplier, one partial-product row per clock.
// Define SEQ_BW_MUL_ACC_EN to let acc_en add each product into p.
module seq_bw_multiplier #(
    parameter int M = 4,
    parameter int N = 4
) (
    input logic                 clk,
    input logic                 rst,
    seq_bw_multiplier_if.slave  bus
);
    localparam int W  = M + N + 1;
    localparam int CW = $clog2(N);

    // Baugh-Wooley constants: -2^(M+N-1) + 2^(M-1) + 2^(N-1), split in two
    localparam logic [W-1:0] K_FIRST =
        (W'(1) << (M - 1)) + (W'(1) << (N - 1));
    localparam logic [W-1:0] K_LAST = W'(1) << (M + N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [M-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            sgn_q;
    logic [W-1:0]    acc;
    logic [CW-1:0]   cnt;

    logic            first;
    logic            last;
    logic [M-1:0]    row;
    logic [W-1:0]    sum;
    logic [M+N-1:0]  prod;

    assign first = (cnt == '0);
    assign last  = (cnt == CW'(N - 1));

    always_comb begin
        row = a_q & {M{b_q[cnt]}};
        if (sgn_q) begin
            if (last) begin
                row[M-2:0] = ~row[M-2:0];
            end else begin
                row[M-1] = ~row[M-1];
            end
        end
    end

    assign sum = acc
               + (W'(row) << cnt)
               + ((sgn_q && first) ? K_FIRST : '0)
               + ((sgn_q && last) ? K_LAST : '0);

    assign prod = sum[M+N-1:0];

`ifdef SEQ_BW_MUL_ACC_EN
    logic acc_q;
`else
    logic unused_acc_en;
    assign unused_acc_en = bus.acc_en;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.p    <= '0;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            acc      <= '0;
`ifdef SEQ_BW_MUL_ACC_EN
            acc_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        sgn_q    <= bus.sgn;
`ifdef SEQ_BW_MUL_ACC_EN
                        acc_q    <= bus.acc_en;
`endif
                        acc      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= sum;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
`ifdef SEQ_BW_MUL_ACC_EN
                        bus.p <= acc_q ? bus.p + prod : prod;
`else
                        bus.p <= prod;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_bw_multiplier.sv
// Directed bench for seq_bw_multiplier (4x4) plus a 6x3 instance
// checked against a behavioural product.
module tb_seq_bw_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_bw_multiplier_if #(.M(4), .N(4)) bus4 ();
    seq_bw_multiplier_if #(.M(6), .N(3)) bus6 ();

    seq_bw_multiplier #(.M(4), .N(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    seq_bw_multiplier #(.M(6), .N(3)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    int nvec = 0;
    int nerr = 0;
    int dones6 = 0;
    int starts6 = 0;

    logic [7:0] last_p;
    int         last_n;
    int         last_nb;

    always @(posedge clk) begin
        if (!rst && bus6.done) dones6++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op4(input logic s, input logic [3:0] aa,
                       input logic [3:0] bb, input logic ac);
        int n;
        int nb;
        bus4.sgn    = s;
        bus4.a      = aa;
        bus4.b      = bb;
        bus4.acc_en = ac;
        bus4.start  = 1'b1;
        step();
        bus4.start  = 1'b0;
        bus4.a      = ~aa;
        bus4.b      = ~bb;
        bus4.sgn    = ~s;
        n  = 0;
        nb = 0;
        while (!bus4.done && n < 20) begin
            if (bus4.busy) nb++;
            step();
            n++;
        end
        last_p  = bus4.p;
        last_n  = n;
        last_nb = nb;
    endtask

    task automatic op6(input logic s, input logic [5:0] aa,
                       input logic [2:0] bb);
        int n;
        int av;
        int bv;
        logic [8:0] e;
        av = s ? int'($signed(aa)) : int'(aa);
        bv = s ? int'($signed(bb)) : int'(bb);
        e  = 9'(av * bv);
        bus6.sgn   = s;
        bus6.a     = aa;
        bus6.b     = bb;
        bus6.start = 1'b1;
        starts6++;
        step();
        bus6.start = 1'b0;
        bus6.a     = 6'($urandom_range(0, 63));
        bus6.b     = 3'($urandom_range(0, 7));
        n = 0;
        while (!bus6.done && n < 20) begin
            step();
            n++;
        end
        chk("m6n3_lat", 64'(n), 64'd3);
        chk("m6n3_p", 64'(bus6.p), 64'(e));
    endtask

    initial begin
        int n;
        int ndone;
        bus4.start = 0; bus4.sgn = 0; bus4.acc_en = 0;
        bus4.a = 0; bus4.b = 0;
        bus6.start = 0; bus6.sgn = 0; bus6.acc_en = 0;
        bus6.a = 0; bus6.b = 0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", 64'(bus4.busy), 64'd0);
        chk("rst_done", 64'(bus4.done), 64'd0);
        chk("rst_p", 64'(bus4.p), 64'd0);

        op4(1'b0, 4'hF, 4'hF, 1'b0);
        chk("uns_ff_p", 64'(last_p), 64'hE1);
        chk("uns_ff_lat", 64'(last_n), 64'd4);
        chk("uns_ff_busy", 64'(last_nb), 64'd4);
        step();
        chk("done_pulse", 64'(bus4.done), 64'd0);
        chk("p_hold", 64'(bus4.p), 64'hE1);

        op4(1'b0, 4'h0, 4'hB, 1'b0);
        chk("uns_0xb", 64'(last_p), 64'h00);
        op4(1'b1, 4'h8, 4'h8, 1'b0);
        chk("s_m8m8", 64'(last_p), 64'h40);
        op4(1'b1, 4'h8, 4'h7, 1'b0);
        chk("s_m8p7", 64'(last_p), 64'hC8);
        op4(1'b1, 4'h3, 4'hB, 1'b0);
        chk("s_3m5", 64'(last_p), 64'hF1);
        op4(1'b1, 4'h0, 4'h8, 1'b0);
        chk("s_0m8", 64'(last_p), 64'h00);
        op4(1'b1, 4'h7, 4'h7, 1'b0);
        chk("s_7x7", 64'(last_p), 64'h31);
        op4(1'b1, 4'hF, 4'hF, 1'b0);
        chk("s_m1m1", 64'(last_p), 64'h01);

        // start held high through RUN, operands changed mid-run
        step();
        bus4.sgn = 0; bus4.a = 4'd3; bus4.b = 4'd2;
        bus4.start = 1'b1;
        step();
        bus4.a = 4'd5; bus4.b = 4'd7;
        n = 0;
        while (!bus4.done && n < 20) begin
            step();
            n++;
        end
        chk("b2b_first", 64'(bus4.p), 64'h06);
        n = 0;
        step();
        n++;
        while (!bus4.done && n < 20) begin
            step();
            n++;
        end
        bus4.start = 1'b0;
        chk("b2b_gap", 64'(n), 64'd5);
        chk("b2b_second", 64'(bus4.p), 64'h23);
        step();

        // reset in the middle of an operation
        bus4.sgn = 0; bus4.a = 4'd9; bus4.b = 4'd9;
        bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 64'(bus4.busy), 64'd0);
        chk("abort_done", 64'(bus4.done), 64'd0);
        chk("abort_p", 64'(bus4.p), 64'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus4.done) ndone++;
            step();
        end
        chk("abort_nodone", 64'(ndone), 64'd0);
        op4(1'b0, 4'd5, 4'd3, 1'b0);
        chk("after_abort", 64'(last_p), 64'h0F);

        op4(1'b1, 4'd3, 4'd5, 1'b0);
        chk("acc_first", 64'(last_p), 64'h0F);
        op4(1'b1, 4'd2, 4'hE, 1'b1);
`ifdef SEQ_BW_MUL_ACC_EN
        chk("acc_second", 64'(last_p), 64'h0B);
`else
        chk("acc_second", 64'(last_p), 64'hFC);
`endif

        op6(1'b1, 6'h20, 3'h4);
        op6(1'b0, 6'h3F, 3'h7);
        for (int i = 0; i < 300; i++) begin
            op6(1'($urandom_range(0, 1)),
                6'($urandom_range(0, 63)),
                3'($urandom_range(0, 7)));
        end
        step();
        step();
        chk("m6n3_dones", 64'(dones6), 64'(starts6));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
